host_tx_scheduler: RTL and testbench

HOST_TX_SCHEDULER -- requirements
Module: host_tx_scheduler

---
 rtl/host_tx_scheduler_if.sv | 26 ++
 rtl/host_tx_scheduler.sv | 157 +++++++++++++++
 tb/tb_host_tx_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_tx_scheduler_if.sv
// rtl/host_tx_scheduler_if.sv - request, packet-sender and status signals of the host transaction scheduler
interface host_tx_scheduler_if;
  logic       sofEnable;
  logic       transReq;
  logic [1:0] transType;
  logic [6:0] transAddr;
  logic [3:0] transEndP;
  logic       sendPacketRdy;
  logic       sendPacketWEn;
  logic [3:0] PID;
  logic [6:0] TxAddr;
  logic [3:0] TxEndP;
  logic       busy;
  logic       transDone;
  logic       sofSent;

  modport master (
    output sofEnable, transReq, transType, transAddr, transEndP, sendPacketRdy,
    input  sendPacketWEn, PID, TxAddr, TxEndP, busy, transDone, sofSent
  );

  modport slave (
    input  sofEnable, transReq, transType, transAddr, transEndP, sendPacketRdy,
    output sendPacketWEn, PID, TxAddr, TxEndP, busy, transDone, sofSent
  );
endinterface

// File: rtl/host_tx_scheduler.sv
// rtl/host_tx_scheduler.sv - USB host frame timer and SOF/token/data packet scheduler
module host_tx_scheduler #(
  parameter int SOF_PERIOD = 48000,
  parameter int SOF_GUARD  = 4096
) (
  input logic                clk,
  input logic                rst,
  host_tx_scheduler_if.slave bus
);
  localparam logic [15:0] LP_RELOAD  = 16'(SOF_PERIOD - 1);
  localparam logic [15:0] LP_GUARD   = 16'(SOF_GUARD);
  localparam logic [3:0]  PID_SOF    = 4'h5;
  localparam logic [3:0]  PID_SETUP  = 4'hD;
  localparam logic [3:0]  PID_OUT    = 4'h1;
  localparam logic [3:0]  PID_IN     = 4'h9;
  localparam logic [3:0]  PID_DATA0  = 4'h3;
  localparam logic [3:0]  PID_DATA1  = 4'hB;
  localparam logic [1:0]  TT_SETUP   = 2'd0;
  localparam logic [1:0]  TT_OUT1    = 2'd2;
  localparam logic [1:0]  TT_IN      = 2'd3;

  typedef enum logic [2:0] {IDLE, SOF_LO, SOF_HI, TOK_LO, TOK_HI, DAT_LO, DAT_HI} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timer;
  logic        r_sof_pending;
  logic        w_sof_take;
  logic        w_start_ok;
  logic [1:0]  r_type, w_type_nxt;
  logic        r_wen, w_wen_nxt;
  logic [3:0]  r_pid, w_pid_nxt;
  logic [6:0]  r_addr, w_addr_nxt;
  logic [3:0]  r_endp, w_endp_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_sof_sent, w_sof_sent_nxt;

  // A transaction may only start if it cannot run into the next SOF slot.
  assign w_start_ok = !bus.sofEnable || (r_timer >= LP_GUARD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer       <= LP_RELOAD;
      r_sof_pending <= 1'b0;
    end else if (!bus.sofEnable) begin
      r_timer       <= LP_RELOAD;
      r_sof_pending <= 1'b0;
    end else if (r_timer == 16'd0) begin
      r_timer       <= LP_RELOAD;
      r_sof_pending <= 1'b1;
    end else begin
      r_timer <= r_timer - 16'd1;
      if (w_sof_take) begin
        r_sof_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_type     <= 2'd0;
      r_wen      <= 1'b0;
      r_pid      <= 4'h0;
      r_addr     <= 7'h0;
      r_endp     <= 4'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sof_sent <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_type     <= w_type_nxt;
      r_wen      <= w_wen_nxt;
      r_pid      <= w_pid_nxt;
      r_addr     <= w_addr_nxt;
      r_endp     <= w_endp_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sof_sent <= w_sof_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_type_nxt     = r_type;
    w_wen_nxt      = 1'b0;
    w_pid_nxt      = r_pid;
    w_addr_nxt     = r_addr;
    w_endp_nxt     = r_endp;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_sof_sent_nxt = 1'b0;
    w_sof_take     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.sendPacketRdy && r_sof_pending) begin
          w_sof_take  = 1'b1;
          w_wen_nxt   = 1'b1;
          w_pid_nxt   = PID_SOF;
          w_state_nxt = SOF_LO;
        end else if (bus.sendPacketRdy && bus.transReq && w_start_ok) begin
          w_type_nxt  = bus.transType;
          w_addr_nxt  = bus.transAddr;
          w_endp_nxt  = bus.transEndP;
          w_busy_nxt  = 1'b1;
          w_wen_nxt   = 1'b1;
          w_state_nxt = TOK_LO;
          if (bus.transType == TT_SETUP) begin
            w_pid_nxt = PID_SETUP;
          end else if (bus.transType == TT_IN) begin
            w_pid_nxt = PID_IN;
          end else begin
            w_pid_nxt = PID_OUT;
          end
        end
      end
      SOF_LO: if (!bus.sendPacketRdy) w_state_nxt = SOF_HI;
      SOF_HI: begin
        if (bus.sendPacketRdy) begin
          w_sof_sent_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      TOK_LO: if (!bus.sendPacketRdy) w_state_nxt = TOK_HI;
      TOK_HI: begin
        if (bus.sendPacketRdy) begin
          if (r_type == TT_IN) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_wen_nxt   = 1'b1;
            w_pid_nxt   = (r_type == TT_OUT1) ? PID_DATA1 : PID_DATA0;
            w_state_nxt = DAT_LO;
          end
        end
      end
      DAT_LO: if (!bus.sendPacketRdy) w_state_nxt = DAT_HI;
      DAT_HI: begin
        if (bus.sendPacketRdy) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.sendPacketWEn = r_wen;
  assign bus.PID           = r_pid;
  assign bus.TxAddr        = r_addr;
  assign bus.TxEndP        = r_endp;
  assign bus.busy          = r_busy;
  assign bus.transDone     = r_done;
  assign bus.sofSent       = r_sof_sent;
endmodule

// File: tb/tb_host_tx_scheduler.sv
// tb/tb_host_tx_scheduler.sv - directed and randomized checks of host_tx_scheduler against a packet-level model
`timescale 1ns/1ps
module tb_host_tx_scheduler;
  localparam int P = 100;
  localparam int G = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_tx_scheduler_if bus();
  host_tx_scheduler #(.SOF_PERIOD(P), .SOF_GUARD(G)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_gap = 5;

  int wen_pid[$];
  int wen_cyc[$];
  int wen_addr[$];
  int wen_ep[$];
  int done_cnt, sof_cnt, done_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] token_pid(input logic [1:0] t);
    case (t)
      2'd0:    return 4'hD;
      2'd3:    return 4'h9;
      default: return 4'h1;
    endcase
  endfunction

  function automatic logic [3:0] data_pid(input logic [1:0] t);
    return (t == 2'd2) ? 4'hB : 4'h3;
  endfunction

  // Packet sender: drops ready one cycle after a strobe, restores it rdy_gap cycles later.
  initial begin
    bus.sendPacketRdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.sendPacketWEn === 1'b1) begin
        @(negedge clk);
        bus.sendPacketRdy = 1'b0;
        repeat (rdy_gap) @(negedge clk);
        bus.sendPacketRdy = 1'b1;
      end
    end
  end

  // Reference model: frame expiries from the count of enabled cycles, packets by phase.
  int          n_en = 0;
  int          tmr;
  bit          sof_due = 0;
  int          phase = 0;
  bit          dropped = 0;
  int          pkts_left = 0;
  logic [1:0]  m_type = 2'd0;
  logic        e_wen, e_busy, e_done, e_sof;
  logic [3:0]  e_pid, e_ep;
  logic [6:0]  e_addr;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      e_wen = 1'b0; e_done = 1'b0; e_sof = 1'b0;
      if (rst) begin
        n_en = 0; sof_due = 0; phase = 0; dropped = 0; pkts_left = 0;
        e_busy = 1'b0; e_pid = 4'h0; e_addr = 7'h0; e_ep = 4'h0;
      end else begin
        tmr = P - 1 - (n_en % P);
        if (phase == 0) begin
          if (bus.sendPacketRdy && sof_due) begin
            e_wen = 1'b1; e_pid = 4'h5; sof_due = 0; phase = 1; dropped = 0;
          end else if (bus.sendPacketRdy && bus.transReq && (!bus.sofEnable || tmr >= G)) begin
            m_type = bus.transType;
            e_wen = 1'b1; e_addr = bus.transAddr; e_ep = bus.transEndP; e_busy = 1'b1;
            e_pid = token_pid(m_type);
            pkts_left = (m_type == 2'd3) ? 0 : 1;
            phase = 2; dropped = 0;
          end
        end else if (!dropped) begin
          if (!bus.sendPacketRdy) dropped = 1;
        end else if (bus.sendPacketRdy) begin
          dropped = 0;
          if (phase == 1) begin
            e_sof = 1'b1; phase = 0;
          end else if (pkts_left > 0) begin
            e_wen = 1'b1; e_pid = data_pid(m_type); pkts_left--;
          end else begin
            e_done = 1'b1; e_busy = 1'b0; phase = 0;
          end
        end
        if (!bus.sofEnable) begin
          sof_due = 0;
        end else begin
          n_en++;
          if (n_en % P == 0) sof_due = 1;
        end
      end
      check("sendPacketWEn", int'(bus.sendPacketWEn), int'(e_wen));
      check("PID", int'(bus.PID), int'(e_pid));
      check("TxAddr", int'(bus.TxAddr), int'(e_addr));
      check("TxEndP", int'(bus.TxEndP), int'(e_ep));
      check("busy", int'(bus.busy), int'(e_busy));
      check("transDone", int'(bus.transDone), int'(e_done));
      check("sofSent", int'(bus.sofSent), int'(e_sof));
      if (bus.sendPacketWEn === 1'b1) begin
        wen_pid.push_back(int'(bus.PID));
        wen_cyc.push_back(cyc);
        wen_addr.push_back(int'(bus.TxAddr));
        wen_ep.push_back(int'(bus.TxEndP));
      end
      if (bus.transDone === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.sofSent === 1'b1) sof_cnt++;
    end
  end

  task automatic clear_logs();
    wen_pid.delete(); wen_cyc.delete(); wen_addr.delete(); wen_ep.delete();
    done_cnt = 0; sof_cnt = 0; done_cyc = 0;
  endtask

  task automatic do_reset(input bit en);
    @(negedge clk);
    rst = 1'b1; bus.transReq = 1'b0; bus.sofEnable = en;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic req_token(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e);
    int k;
    bus.transType = t; bus.transAddr = a; bus.transEndP = e; bus.transReq = 1'b1;
    k = 0;
    while (!(bus.sendPacketWEn === 1'b1 && bus.PID != 4'h5) && k < 400) begin
      @(negedge clk);
      k++;
    end
    bus.transReq = 1'b0;
    check("token_timeout", (k < 400) ? 1 : 0, 1);
  endtask

  task automatic wait_done();
    int k;
    int d0;
    k = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", (k < 400) ? 1 : 0, 1);
  endtask

  initial begin
    int k;
    bus.sofEnable = 1'b0; bus.transReq = 1'b0; bus.transType = 2'd0;
    bus.transAddr = 7'h0; bus.transEndP = 4'h0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("rst_wen", int'(bus.sendPacketWEn), 0);
    check("rst_pid", int'(bus.PID), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_txaddr", int'(bus.TxAddr), 0);

    // Free-running SOF only.
    do_reset(1'b1);
    repeat (350) @(negedge clk);
    check("sof_count", wen_pid.size(), 3);
    if (wen_pid.size() == 3) begin
      check("sof_pid0", wen_pid[0], 5);
      check("sof_pid2", wen_pid[2], 5);
      check("sof_interval1", wen_cyc[1] - wen_cyc[0], 100);
      check("sof_interval2", wen_cyc[2] - wen_cyc[1], 100);
    end
    check("sofsent_count", sof_cnt, 3);

    // SETUP with SOF disabled.
    do_reset(1'b0);
    req_token(2'd0, 7'h12, 4'h3);
    wait_done();
    repeat (5) @(negedge clk);
    check("setup_strobes", wen_pid.size(), 2);
    if (wen_pid.size() == 2) begin
      check("setup_tok_pid", wen_pid[0], 13);
      check("setup_addr", wen_addr[0], 18);
      check("setup_endp", wen_ep[0], 3);
      check("setup_data_pid", wen_pid[1], 3);
    end
    check("setup_done", done_cnt, 1);

    // IN: token only.
    clear_logs();
    req_token(2'd3, 7'h55, 4'hA);
    wait_done();
    repeat (5) @(negedge clk);
    check("in_strobes", wen_pid.size(), 1);
    if (wen_pid.size() == 1) check("in_pid", wen_pid[0], 9);
    check("in_done", done_cnt, 1);

    // Request raised at timer=10 is deferred behind the SOF.
    do_reset(1'b1);
    repeat (89) @(negedge clk);
    req_token(2'd1, 7'h21, 4'h5);
    wait_done();
    check("defer_strobes", wen_pid.size(), 3);
    if (wen_pid.size() == 3) begin
      check("defer_first_sof", wen_pid[0], 5);
      check("defer_token", wen_pid[1], 1);
      check("defer_data", wen_pid[2], 3);
    end

    // Frame expiry during an OUT/DATA1 transaction; slow sender stretches it.
    do_reset(1'b1);
    rdy_gap = 15;
    repeat (69) @(negedge clk);
    req_token(2'd2, 7'h3C, 4'h7);
    wait_done();
    repeat (20) @(negedge clk);
    rdy_gap = 5;
    check("exp_strobes", wen_pid.size(), 3);
    if (wen_pid.size() == 3) begin
      check("exp_tok", wen_pid[0], 1);
      check("exp_data", wen_pid[1], 11);
      check("exp_sof", wen_pid[2], 5);
      check("exp_sof_next", wen_cyc[2] - done_cyc, 1);
    end
    check("exp_sofsent", sof_cnt, 1);
    repeat (20) @(negedge clk);

    // Reset while waiting in the data phase.
    do_reset(1'b0);
    req_token(2'd1, 7'h11, 4'h2);
    k = 0;
    while (!(bus.sendPacketWEn === 1'b1 && bus.PID == 4'h3) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_data_timeout", (k < 50) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wen", int'(bus.sendPacketWEn), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_pid", int'(bus.PID), 0);
    check("abort_txaddr", int'(bus.TxAddr), 0);
    check("abort_txendp", int'(bus.TxEndP), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_strobe", wen_pid.size(), 2);
    req_token(2'd3, 7'h44, 4'h9);
    wait_done();
    check("abort_recover_done", done_cnt, 1);
    if (wen_pid.size() == 3) check("abort_recover_pid", wen_pid[2], 9);

    // Randomized transactions, sender latency and spacing, SOF on and off.
    for (int r = 0; r < 4; r++) begin
      do_reset(r[0]);
      for (int i = 0; i < 8; i++) begin
        rdy_gap = $urandom_range(1, 8);
        req_token(2'($urandom_range(0, 3)), 7'($urandom), 4'($urandom));
        wait_done();
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("rand_done_count", done_cnt, 8);
    end
    rdy_gap = 5;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
